imem_fetch_arbiter: RTL and testbench

- Sequences the 5-cycle, 64-bit-line instruction memory and shares it between two readers: port 0 (IF stage) and port 1 (loader/debug reader).
- Holds the last fetched line in a one-entry line buffer, so same-line requests return in 1 cycle.
- Round-robin arbitration.
- Sits between the pipeline front end and the instruction memory; it is the only driver of the memory address.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_line_buffer.sv | 41 ++++
 rtl/imem_fetch_arbiter.sv | 157 +++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory fetch arbiter.
package imem_pkg;

    // Arbiter sequencing states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RETARGET = 2'd1,
        ST_ACCESS   = 2'd2
    } state_t;

    // Byte-offset bits inside one 64-bit memory line.
    localparam int LINE_OFF_W = 3;

    // Memory address after reset: the last line of the address space.
    localparam logic [15:0] MEM_ADDR_RESET = 16'hFFF8;

    // Width of a line tag (the byte address without the in-line offset).
    function automatic int tag_w(input int addr_w);
        return addr_w - LINE_OFF_W;
    endfunction

endpackage

// File: rtl/imem_line_buffer.sv
// One-entry line buffer: remembers the most recently fetched memory line
// and reports combinationally whether a looked-up tag matches it.
module imem_line_buffer #(
    parameter int TAG_W  = 13,
    parameter int LINE_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fill_en,
    input  logic [TAG_W-1:0]  fill_tag,
    input  logic [LINE_W-1:0] fill_data,
    input  logic [TAG_W-1:0]  lookup_tag,
    output logic              hit,
    output logic [LINE_W-1:0] line_data
);

    logic              valid;
    logic [TAG_W-1:0]  tag;

    // Valid flag: cleared by reset, set by the first fill, never cleared otherwise.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= 1'b0;
        end else if (fill_en) begin
            valid <= 1'b1;
        end
    end

    // Tag and line payload.
    // NOTE: payload storage is not reset; valid alone guards it, which keeps
    // the reset net off the wide data register.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            tag       <= fill_tag;
            line_data <= fill_data;
        end
    end

    assign hit = valid && (tag == lookup_tag);

endmodule

// File: rtl/imem_fetch_arbiter.sv
// Shares a fixed-latency, 64-bit-line instruction memory between the IF
// stage (port 0) and a loader/debug reader (port 1). Round-robin grant in
// IDLE; same-line requests are served from a one-entry line buffer.
module imem_fetch_arbiter
    import imem_pkg::*;
#(
    parameter int ADDR_W      = 16,
    parameter int LINE_W      = 64,
    parameter int MEM_LATENCY = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [ADDR_W-1:0] req0_addr,
    output logic              resp0_valid,
    output logic [LINE_W-1:0] resp0_data,
    input  logic              req1_valid,
    input  logic [ADDR_W-1:0] req1_addr,
    output logic              resp1_valid,
    output logic [LINE_W-1:0] resp1_data,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [LINE_W-1:0] mem_ins,
    output logic              busy
);

    localparam int                TAG_W      = tag_w(ADDR_W);
    localparam int                CNT_W      = $clog2(MEM_LATENCY + 1);
    localparam logic [ADDR_W-1:0] ADDR_RESET = ADDR_W'(MEM_ADDR_RESET);
    localparam logic [CNT_W-1:0]  CNT_DONE   = CNT_W'(MEM_LATENCY);
    localparam logic [LINE_OFF_W-1:0] OFF_ZERO = '0;

    state_t             state;
    logic               last_grant;
    logic [CNT_W-1:0]   cnt;
    logic [TAG_W-1:0]   pend_tag;
    logic               pend_port;

    logic               elig0;
    logic               elig1;
    logic               grant_any;
    logic               grant_port;
    logic [TAG_W-1:0]   grant_tag;
    logic [TAG_W-1:0]   next_tag;
    logic               fill_en;
    logic               buf_hit;
    logic [LINE_W-1:0]  buf_data;

    // The in-line byte offset never matters: the whole line is returned.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req0_addr[LINE_OFF_W-1:0], req1_addr[LINE_OFF_W-1:0]};

    // Eligibility and round-robin choice; a port is ignored in its response cycle.
    // NOTE: every combinational output gets a default first so no path
    // through the block leaves a value unassigned and infers a latch.
    always_comb begin
        elig0      = 1'b0;
        elig1      = 1'b0;
        grant_any  = 1'b0;
        grant_port = 1'b0;
        grant_tag  = '0;
        next_tag   = '0;
        elig0      = req0_valid && !resp0_valid;
        elig1      = req1_valid && !resp1_valid;
        grant_any  = elig0 || elig1;
        // Port 1 wins when it is alone, or on a tie when port 0 was granted last.
        grant_port = elig1 && (!elig0 || !last_grant);
        grant_tag  = grant_port ? req1_addr[ADDR_W-1:LINE_OFF_W]
                                : req0_addr[ADDR_W-1:LINE_OFF_W];
        next_tag   = grant_tag + TAG_W'(1);
    end

    assign fill_en = (state == ST_ACCESS) && (cnt == CNT_DONE);
    assign busy    = (state != ST_IDLE);

    imem_line_buffer #(
        .TAG_W  (TAG_W),
        .LINE_W (LINE_W)
    ) u_line_buffer (
        .clk        (clk),
        .rst_n      (rst_n),
        .fill_en    (fill_en),
        .fill_tag   (pend_tag),
        .fill_data  (mem_ins),
        .lookup_tag (grant_tag),
        .hit        (buf_hit),
        .line_data  (buf_data)
    );

    // Arbitration, memory sequencing and registered responses.
    // NOTE: all state here uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp0_data  <= '0;
            resp1_data  <= '0;
            mem_addr    <= ADDR_RESET;
            last_grant  <= 1'b1;
            cnt         <= '0;
            pend_tag    <= '0;
            pend_port   <= 1'b0;
        end else begin
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (grant_any) begin
                        last_grant <= grant_port;
                        pend_port  <= grant_port;
                        pend_tag   <= grant_tag;
                        if (buf_hit) begin
                            if (grant_port) begin
                                resp1_valid <= 1'b1;
                                resp1_data  <= buf_data;
                            end else begin
                                resp0_valid <= 1'b1;
                                resp0_data  <= buf_data;
                            end
                        end else if (grant_tag != mem_addr[ADDR_W-1:LINE_OFF_W]) begin
                            mem_addr <= {grant_tag, OFF_ZERO};
                            cnt      <= '0;
                            state    <= ST_ACCESS;
                        end else begin
                            // The memory only restarts on an address change, so
                            // step away for one cycle before fetching this line.
                            mem_addr <= {next_tag, OFF_ZERO};
                            state    <= ST_RETARGET;
                        end
                    end
                end
                ST_RETARGET: begin
                    mem_addr <= {pend_tag, OFF_ZERO};
                    cnt      <= '0;
                    state    <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (cnt == CNT_DONE) begin
                        if (pend_port) begin
                            resp1_valid <= 1'b1;
                            resp1_data  <= mem_ins;
                        end else begin
                            resp0_valid <= 1'b1;
                            resp0_data  <= mem_ins;
                        end
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Directed bench for imem_fetch_arbiter with a behavioural 5-cycle memory.
// Latencies are counted in edges from the request being presented: the grant
// edge is the first, so a hit answers on edge 1, a miss on edge 7, a
// retargeted miss on edge 8.
module tb_imem_fetch_arbiter;

    localparam int ADDR_W = 16;
    localparam int LINE_W = 64;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic              resp0_valid;
    logic [LINE_W-1:0] resp0_data;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic              resp1_valid;
    logic [LINE_W-1:0] resp1_data;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_ins;
    logic              busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_fetch_arbiter #(
        .ADDR_W      (ADDR_W),
        .LINE_W      (LINE_W),
        .MEM_LATENCY (5)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_addr   (req0_addr),
        .resp0_valid (resp0_valid),
        .resp0_data  (resp0_data),
        .req1_valid  (req1_valid),
        .req1_addr   (req1_addr),
        .resp1_valid (resp1_valid),
        .resp1_data  (resp1_data),
        .mem_addr    (mem_addr),
        .mem_ins     (mem_ins),
        .busy        (busy)
    );

    // ---------------- memory model ----------------
    function automatic logic [63:0] line_contents(input logic [12:0] line);
        case (line)
            13'd0:   return 64'h0000_0000_0000_E188;
            13'd1:   return 64'h0000_0000_0000_0C70;
            13'd2:   return 64'h0000_0000_0000_CF8A;
            default: return {16'hBEEF, 3'b000, line, 16'h5A5A, 3'b000, line};
        endcase
    endfunction

    logic [ADDR_W-1:0] seen_addr;
    int                stable_cnt = 0;
    int                cnt_now;
    assign cnt_now = (mem_addr !== seen_addr) ? 1 :
                     (stable_cnt < 100 ? stable_cnt + 1 : stable_cnt);

    // Counts edges with a stable address; data is valid only for the cycle
    // after the 5th such edge, X at all other times.
    always @(posedge clk) begin
        seen_addr  <= mem_addr;
        stable_cnt <= cnt_now;
        if (cnt_now == 5) mem_ins <= line_contents(mem_addr[15:3]);
        else              mem_ins <= 'x;
    end

    // ---------------- helpers (stimulus only) ----------------
    task automatic wait_port(input int port, input int budget, output int cycles,
                             output int busy_cycles, output logic [15:0] ma0,
                             output logic [15:0] ma1, output logic [63:0] data);
        cycles      = -1;
        busy_cycles = 0;
        ma0         = 'x;
        ma1         = 'x;
        data        = 'x;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (n == 1) ma0 = mem_addr;
            if (n == 2) ma1 = mem_addr;
            if (busy) busy_cycles++;
            if ((port == 0) ? resp0_valid : resp1_valid) begin
                cycles = n;
                data   = (port == 0) ? resp0_data : resp1_data;
                break;
            end
        end
        if (port == 0) req0_valid = 1'b0;
        else           req1_valid = 1'b0;
    endtask

    task automatic run_pair(input logic [15:0] a0, input logic [15:0] a1, input int budget,
                            output int c0, output int c1,
                            output logic [63:0] d0, output logic [63:0] d1);
        c0 = -1; c1 = -1; d0 = 'x; d1 = 'x;
        req0_addr = a0; req0_valid = 1'b1;
        req1_addr = a1; req1_valid = 1'b1;
        for (int n = 1; n <= budget; n++) begin
            @(posedge clk); #1;
            if (resp0_valid && c0 < 0) begin c0 = n; d0 = resp0_data; req0_valid = 1'b0; end
            if (resp1_valid && c1 < 0) begin c1 = n; d1 = resp1_data; req1_valid = 1'b0; end
            if (c0 > 0 && c1 > 0) break;
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
        req0_addr = '0; req1_addr = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL reset_resp0_valid: got %b expected 0", resp0_valid); end
        checks++; if (resp1_valid !== 1'b0) begin errors++; $display("FAIL reset_resp1_valid: got %b expected 0", resp1_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (mem_addr !== 16'hFFF8) begin errors++; $display("FAIL reset_mem_addr: got %h expected fff8", mem_addr); end
        checks++; if (resp0_data !== 64'h0 || resp1_data !== 64'h0) begin errors++; $display("FAIL reset_resp_data: got %h/%h expected 0/0", resp0_data, resp1_data); end
        rst_n = 1'b1;
    endtask

    task automatic test_cold_miss();
        int cyc, bcyc; logic [15:0] ma0, ma1; logic [63:0] d;
        req0_addr = 16'h0000; req0_valid = 1'b1;
        wait_port(0, 20, cyc, bcyc, ma0, ma1, d);
        checks++; if (ma0 !== 16'h0000) begin errors++; $display("FAIL cold_mem_addr: got %h expected 0000", ma0); end
        checks++; if (cyc !== 7) begin errors++; $display("FAIL cold_latency: got %0d expected 7", cyc); end
        checks++; if (d !== 64'h0000_0000_0000_E188) begin errors++; $display("FAIL cold_data: got %h expected e188", d); end
        checks++; if (bcyc !== 6) begin errors++; $display("FAIL cold_busy_cycles: got %0d expected 6", bcyc); end
        @(posedge clk); #1;
        checks++; if (resp0_valid !== 1'b0) begin errors++; $display("FAIL cold_pulse_width: got %b expected 0", resp0_valid); end
        checks++; if (resp0_data !== 64'h0000_0000_0000_E188) begin errors++; $display("FAIL cold_data_hold: got %h expected e188", resp0_data); end
    endtask

    task automatic test_hit();
        int cyc, bcyc; logic [15:0] ma0, ma1; logic [63:0] d;
        req0_addr = 16'h0004; req0_valid = 1'b1;
        wait_port(0, 20, cyc, bcyc, ma0, ma1, d);
        checks++; if (cyc !== 1) begin errors++; $display("FAIL hit_latency: got %0d expected 1", cyc); end
        checks++; if (d !== 64'h0000_0000_0000_E188) begin errors++; $display("FAIL hit_data: got %h expected e188", d); end
        checks++; if (ma0 !== 16'h0000) begin errors++; $display("FAIL hit_mem_addr: got %h expected 0000", ma0); end
        checks++; if (bcyc !== 0) begin errors++; $display("FAIL hit_busy: got %0d expected 0", bcyc); end
    endtask

    task automatic test_reset_during_access();
        int cyc, bcyc, pulses; logic [15:0] ma0, ma1; logic [63:0] d;
        req0_addr = 16'h0018; req0_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midreset_busy_before: got %b expected 1", busy); end
        req0_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy_after: got %b expected 0", busy); end
        checks++; if (mem_addr !== 16'hFFF8) begin errors++; $display("FAIL midreset_mem_addr: got %h expected fff8", mem_addr); end
        pulses = 0;
        for (int n = 0; n < 8; n++) begin
            @(posedge clk); #1;
            if (resp0_valid || resp1_valid) pulses++;
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midreset_dropped: got %0d pulses expected 0", pulses); end
        // Line 0 was buffered before the reset; it must be fetched again.
        req0_addr = 16'h0004; req0_valid = 1'b1;
        wait_port(0, 20, cyc, bcyc, ma0, ma1, d);
        checks++; if (cyc !== 7) begin errors++; $display("FAIL midreset_refetch_latency: got %0d expected 7", cyc); end
        checks++; if (d !== 64'h0000_0000_0000_E188) begin errors++; $display("FAIL midreset_refetch_data: got %h expected e188", d); end
    endtask

    task automatic test_round_robin();
        int c0, c1, cyc, bcyc; logic [63:0] d0, d1, d; logic [15:0] ma0, ma1;
        apply_reset(2);
        // Both miss: port 0 wins the first tie, port 1 is fetched afterwards.
        run_pair(16'h0008, 16'h0010, 40, c0, c1, d0, d1);
        checks++; if (c0 !== 7) begin errors++; $display("FAIL rr_first_latency: got %0d expected 7", c0); end
        checks++; if (d0 !== 64'h0000_0000_0000_0C70) begin errors++; $display("FAIL rr_first_data: got %h expected 0c70", d0); end
        checks++; if (c1 !== 14) begin errors++; $display("FAIL rr_second_latency: got %0d expected 14", c1); end
        checks++; if (d1 !== 64'h0000_0000_0000_CF8A) begin errors++; $display("FAIL rr_second_data: got %h expected cf8a", d1); end
        // Tie of two hits after port 1 was last: port 0 first.
        run_pair(16'h0010, 16'h0014, 20, c0, c1, d0, d1);
        checks++; if (c0 !== 1 || c1 !== 2) begin errors++; $display("FAIL rr_tie_after_p1: got %0d/%0d expected 1/2", c0, c1); end
        // Single port-0 hit, then a tie: port 1 first.
        req0_addr = 16'h0014; req0_valid = 1'b1;
        wait_port(0, 20, cyc, bcyc, ma0, ma1, d);
        checks++; if (cyc !== 1 || d !== 64'h0000_0000_0000_CF8A) begin errors++; $display("FAIL rr_single_hit: got %0d/%h expected 1/cf8a", cyc, d); end
        run_pair(16'h0010, 16'h0010, 20, c0, c1, d0, d1);
        checks++; if (c1 !== 1 || c0 !== 2) begin errors++; $display("FAIL rr_tie_after_p0: got p1=%0d p0=%0d expected 1/2", c1, c0); end
    endtask

    task automatic test_same_line();
        int c0, c1; logic [63:0] d0, d1;
        // Port 0 was granted last, so port 1 takes the miss and port 0 hits after it.
        run_pair(16'h0028, 16'h002C, 40, c0, c1, d0, d1);
        checks++; if (c1 !== 7) begin errors++; $display("FAIL same_line_p1_latency: got %0d expected 7", c1); end
        checks++; if (c0 !== 8) begin errors++; $display("FAIL same_line_p0_latency: got %0d expected 8", c0); end
        checks++; if (d0 !== 64'hBEEF_0005_5A5A_0005 || d1 !== 64'hBEEF_0005_5A5A_0005) begin errors++; $display("FAIL same_line_data: got %h/%h expected beef00055a5a0005", d0, d1); end
    endtask

    task automatic test_retarget();
        int cyc, bcyc; logic [15:0] ma0, ma1; logic [63:0] d;
        apply_reset(2);
        req1_addr = 16'hFFF8; req1_valid = 1'b1;
        wait_port(1, 20, cyc, bcyc, ma0, ma1, d);
        checks++; if (ma0 !== 16'h0000) begin errors++; $display("FAIL retarget_step_addr: got %h expected 0000", ma0); end
        checks++; if (ma1 !== 16'hFFF8) begin errors++; $display("FAIL retarget_final_addr: got %h expected fff8", ma1); end
        checks++; if (cyc !== 8) begin errors++; $display("FAIL retarget_latency: got %0d expected 8", cyc); end
        checks++; if (bcyc !== 7) begin errors++; $display("FAIL retarget_busy_cycles: got %0d expected 7", bcyc); end
        checks++; if (d !== 64'hBEEF_1FFF_5A5A_1FFF) begin errors++; $display("FAIL retarget_data: got %h expected beef1fff5a5a1fff", d); end
        req0_addr = 16'hFFFC; req0_valid = 1'b1;
        wait_port(0, 20, cyc, bcyc, ma0, ma1, d);
        checks++; if (cyc !== 1 || d !== 64'hBEEF_1FFF_5A5A_1FFF) begin errors++; $display("FAIL retarget_then_hit: got %0d/%h expected 1/beef1fff5a5a1fff", cyc, d); end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_hit();
        test_reset_during_access();
        test_round_robin();
        test_same_line();
        test_retarget();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
